// File: rtl/mux16_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mux16_serial_ctrl                                                 |
// | Loads a 16-bit word onto a 16:1 mux and walks the select, streaming mux_o  |
// | out as a framed serial bit stream. MUX16_SERIAL_PARITY_EN adds a 17th bit. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux16_serial_ctrl #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] mux_i,
    output logic [3:0]  mux_s,
    input  logic        mux_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_bit,
    output logic        out_first,
    output logic        out_last,
    output logic        busy
);

    localparam logic [3:0] c_START_IDX = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [3:0] c_END_IDX   = MSB_FIRST ? 4'd0  : 4'd15;
    localparam bit         c_HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [3:0] c_GAP_LOAD  = c_HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;
`ifdef MUX16_SERIAL_PARITY_EN
    localparam bit         c_LAST_IN_SEND = 1'b0;
`else
    localparam bit         c_LAST_IN_SEND = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
`ifdef MUX16_SERIAL_PARITY_EN
        ,
        ST_PAR  = 2'd3
`endif
    } state_t;

    state_t      state_q;
    logic [15:0] mux_i_q;
    logic [3:0]  mux_s_q;
    logic [3:0]  mux_s_d;
    logic [3:0]  gap_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        out_first_q;
    logic        out_last_q;
    logic        busy_q;
    logic        w_at_end;
    logic        w_finish;
`ifdef MUX16_SERIAL_PARITY_EN
    logic        par_q;
`endif

    assign mux_s_d  = MSB_FIRST ? (mux_s_q - 4'd1) : (mux_s_q + 4'd1);
    assign w_at_end = (mux_s_q == c_END_IDX);

    // Final transfer of a frame: the end-index bit, or the parity bit when enabled.
`ifdef MUX16_SERIAL_PARITY_EN
    assign w_finish = out_ready && (state_q == ST_PAR);
    assign out_bit  = (state_q == ST_PAR) ? par_q : mux_o;
`else
    assign w_finish = out_ready && (state_q == ST_SEND) && w_at_end;
    assign out_bit  = mux_o;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mux_i_q     <= 16'd0;
            mux_s_q     <= 4'd0;
            gap_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUX16_SERIAL_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mux_i_q     <= in_data;
                        mux_s_q     <= c_START_IDX;
                        state_q     <= ST_SEND;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_first_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef MUX16_SERIAL_PARITY_EN
                        par_q       <= ^in_data;
`endif
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (!w_at_end) begin
                            mux_s_q     <= mux_s_d;
                            out_first_q <= 1'b0;
                            out_last_q  <= c_LAST_IN_SEND && (mux_s_d == c_END_IDX);
                        end
`ifdef MUX16_SERIAL_PARITY_EN
                        else begin
                            state_q     <= ST_PAR;
                            out_first_q <= 1'b0;
                            out_last_q  <= 1'b1;
                        end
`endif
                    end
                end
                ST_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: begin
                    // ST_PAR only waits; its exit is handled by w_finish below.
                end
            endcase

            if (w_finish) begin
                out_valid_q <= 1'b0;
                out_first_q <= 1'b0;
                out_last_q  <= 1'b0;
                if (c_HAS_GAP) begin
                    state_q <= ST_GAP;
                    gap_q   <= c_GAP_LOAD;
                end else begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign mux_i     = mux_i_q;
    assign mux_s     = mux_s_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/mux16_serial_ctrl.md
Name: mux16_serial_ctrl

Overview:
- Sequential parallel-to-serial controller that drives a 16:1 bit-select mux.
- Accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select through all 16 positions and emits the mux output as a serial bit stream with its own valid/ready handshake.
- Sits directly upstream of the mux: it feeds the mux inputs and select, and consumes the mux output.

Parameters:
- MSB_FIRST, 0: 0 = select order 0→15; 1 = select order 15→0.
- GAP_CYCLES, 0: idle cycles (0..15) enforced after a frame's last bit before in_ready reasserts.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  16  parallel word.
- mux_i  output  16  held word driven to the mux data inputs.
- mux_s  output  4  mux select.
- mux_o  input  1  mux output; combinational function of mux_i/mux_s.
- out_valid  output  1  serial bit valid.
- out_ready  input  1  downstream accepts bit.
- out_bit  output  1  serial data bit.
- out_first  output  1  marks the first bit of a frame.
- out_last  output  1  marks the last bit of a frame.
- busy  output  1  frame in progress or gap pending.

Behaviour:
- Reset is asynchronous and active-low: while rst_n=0, all registers clear immediately.
  - state=IDLE, mux_i=0, mux_s=0, gap count=0.
  - out_valid=0, out_first=0, out_last=0, busy=0.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-frame discards the frame with no partial completion.
- States: IDLE, SEND, GAP (plus PAR under PARITY_EN).
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&in_ready at an edge → mux_i<=in_data, mux_s<=(MSB_FIRST?15:0), state<=SEND.
  - First bit is valid the following cycle (1-cycle load latency).
- SEND:
  - in_ready=0, out_valid=1, out_bit=mux_o (combinational pass-through, no extra register).
  - out_first=1 when mux_s equals the start index.
  - out_last=1 when mux_s equals the end index.
  - On out_valid&out_ready: if not at end index, mux_s steps by ±1 per MSB_FIRST. At end index → GAP if GAP_CYCLES>0, else IDLE.
  - out_ready=0 holds mux_s, out_bit and the flags stable indefinitely (no drop, no repeat).
- GAP:
  - busy=1, in_ready=0, out_valid=0.
  - Counter loads GAP_CYCLES−1 on entry and decrements each cycle; at 0 → IDLE.
- mux_i is held constant for the whole frame and changes only on an accepted load.
- busy=1 in every state except IDLE.
- No back-to-back overlap: with GAP_CYCLES=0, the next word is accepted in the IDLE cycle after the last bit transfer, giving minimum frame period 17 cycles.
- in_valid while not in IDLE is ignored; upstream must hold in_valid/in_data until accepted.
- Select wraps are impossible: the index never steps past the end index.

Optional Feature:
- Macro: MUX16_SERIAL_PARITY_EN.
- Defined:
  - At load, register even parity (XOR of in_data).
  - After the end-index transfer, enter PAR: out_valid=1, out_bit=parity register (not mux_o), out_last=1.
  - During SEND, out_last=0.
  - Frame is 17 bits.
  - PAR transfer → GAP/IDLE as above.
- Undefined: no parity register, no PAR state, frame is 16 bits.

Test Plan:
- Reset: rst_n=0 mid-frame at bit 7 → next cycle out_valid=0, busy=0, mux_s=0, in_ready=1 after release.
- Basic LSB-first: MSB_FIRST=0, out_ready=1, load 16'hA5C3 → bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles; out_first on bit 0, out_last on bit 15; in_ready=1 on cycle 17.
- MSB-first: MSB_FIRST=1, load 16'h8001 → first bit 1, then fourteen 0s, last bit 1; mux_s sequence 15→0.
- Backpressure: out_ready toggled 1,0,0,1 → mux_s and out_bit stable during stalls; exactly 16 transfers total.
- Gap: GAP_CYCLES=3, two words queued back-to-back → in_ready low for exactly 3 cycles after the last transfer; second frame starts correctly.
- Parity (MUX16_SERIAL_PARITY_EN): load 16'h0007 → 17 bits, 17th bit = 1, out_last only on bit 17; load 16'h0003 → 17th bit = 0.
